// File: rtl/alu_op_sequencer.sv
// Issue controller for the small integer ALU.
// Single-cycle logic/shift/add-sub plus iterative shift-add MUL and restoring DIV.
module alu_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;

    // EXEC is the one cycle in which the latched operands are evaluated
    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic [WIDTH:0]   ext_a, ext_b, cin_w;
    logic [WIDTH:0]   arith;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   rem_sh;

    assign ext_a = {1'b0, a_q};
    assign ext_b = {1'b0, b_q};
    assign cin_w = {{WIDTH{1'b0}}, carry_q};

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

    // Next-state, datapath step and result loading
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        ill_d   = ill_q;
        arith   = '0;
        sum_w   = '0;
        rem_sh  = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = opcode;
                    a_d   = op_a;
                    b_d   = op_b;
                    cnt_d = '0;
                    acc_d = '0;
                    mq_d  = (opcode == OP_MUL) ? op_b : op_a;
                    if (opcode == OP_MUL ||
                        (opcode == OP_DIV && op_b != '0))
                        state_d = ITER;
                    else
                        state_d = EXEC;
                end
            end
            EXEC: begin
                lo_d    = '0;
                hi_d    = '0;
                dbz_d   = 1'b0;
                ill_d   = 1'b0;
                state_d = DONE;
                case (op_q)
                    4'd0: lo_d = a_q & b_q;
                    4'd1: lo_d = ~(a_q & b_q);
                    4'd2: lo_d = a_q | b_q;
                    4'd3: lo_d = ~(a_q | b_q);
                    4'd4: lo_d = a_q ^ b_q;
                    4'd5: lo_d = ~(a_q ^ b_q);
                    4'd6: lo_d = ~a_q;
                    4'd7: lo_d = a_q << 1;
                    4'd8: lo_d = a_q >> 1;
                    4'd9, 4'd10, 4'd11, 4'd12: begin
                        unique case (op_q)
                            4'd9:    arith = ext_a + ext_b;
                            4'd10:   arith = ext_a + ext_b + cin_w;
                            4'd11:   arith = ext_a - ext_b;
                            default: arith = ext_a - ext_b - cin_w;
                        endcase
                        lo_d    = arith[WIDTH-1:0];
                        carry_d = arith[WIDTH];
                    end
                    OP_DIV:  dbz_d = 1'b1;
                    default: ill_d = 1'b1;
                endcase
            end
            ITER: begin
                if (op_q == OP_MUL) begin
                    sum_w = {1'b0, acc_q} + (mq_q[0] ? ext_a : '0);
                    {acc_d, mq_d} = {sum_w, mq_q[WIDTH-1:1]};
                end else begin
                    rem_sh = {acc_q, mq_q[WIDTH-1]};
                    if (rem_sh >= ext_b) begin
                        acc_d = WIDTH'(rem_sh - ext_b);
                        mq_d  = (mq_q << 1) | WIDTH'(1);
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        mq_d  = mq_q << 1;
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    lo_d    = mq_d;
                    hi_d    = acc_d;
                    dbz_d   = 1'b0;
                    ill_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer.
// Each task drives one scenario and checks hand-computed results.
module tb_alu_op_sequencer;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result_lo;
    logic [3:0] result_hi;
    logic       carry;
    logic       div_by_zero;
    logic       illegal_op;

    int n_chk;
    int n_fail;

    alu_op_sequencer #(.WIDTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .carry      (carry),
        .div_by_zero(div_by_zero),
        .illegal_op (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one op and wait (bounded) for out_valid; lat = edges after accept
    task automatic do_op(input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        opcode   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({in_ready, out_valid, result_lo, result_hi, carry,
             div_by_zero, illegal_op} !== {1'b1, 1'b0, 4'd0, 4'd0,
             1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b lo=%0d hi=%0d c=%b dz=%b il=%b expected 1 0 0 0 0 0 0",
                     in_ready, out_valid, result_lo, result_hi, carry,
                     div_by_zero, illegal_op);
        end
    endtask

    task automatic test_add_chain();
        int lat;
        do_op(4'd9, 4'd9, 4'd8, lat);
        n_chk++;
        if ({result_lo, result_hi, carry} !== {4'd1, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL add: lo=%0d hi=%0d c=%b expected 1 0 1",
                     result_lo, result_hi, carry);
        end
        n_chk++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL add_latency: got %0d expected 1", lat);
        end
        accept_result();
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_release: rdy=%b vld=%b expected 1 0",
                     in_ready, out_valid);
        end
        do_op(4'd10, 4'd2, 4'd3, lat);
        n_chk++;
        if ({result_lo, carry} !== {4'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL addc: lo=%0d c=%b expected 6 0",
                     result_lo, carry);
        end
        accept_result();
    endtask

    task automatic test_sub_chain();
        int lat;
        do_op(4'd11, 4'd3, 4'd5, lat);
        n_chk++;
        if ({result_lo, carry} !== {4'd14, 1'b1}) begin
            n_fail++;
            $display("FAIL sub: lo=%0d c=%b expected 14 1",
                     result_lo, carry);
        end
        accept_result();
        do_op(4'd12, 4'd7, 4'd2, lat);
        n_chk++;
        if ({result_lo, carry} !== {4'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL subb: lo=%0d c=%b expected 4 0",
                     result_lo, carry);
        end
        accept_result();
        do_op(4'd0, 4'd12, 4'd10, lat);
        n_chk++;
        if ({result_lo, result_hi, carry} !== {4'd8, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL and: lo=%0d hi=%0d c=%b expected 8 0 0",
                     result_lo, result_hi, carry);
        end
        accept_result();
    endtask

    task automatic test_mul_div();
        int lat;
        do_op(4'd13, 4'd15, 4'd15, lat);
        n_chk++;
        if ({result_hi, result_lo} !== 8'd225) begin
            n_fail++;
            $display("FAIL mul: hi=%0d lo=%0d expected 14 1",
                     result_hi, result_lo);
        end
        n_chk++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d expected 4", lat);
        end
        accept_result();
        do_op(4'd14, 4'd13, 4'd4, lat);
        n_chk++;
        if ({result_lo, result_hi, div_by_zero, carry} !==
            {4'd3, 4'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL div: q=%0d r=%0d dz=%b c=%b expected 3 1 0 0",
                     result_lo, result_hi, div_by_zero, carry);
        end
        n_chk++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL div_latency: got %0d expected 4", lat);
        end
        accept_result();
        do_op(4'd13, 4'd6, 4'd11, lat);
        n_chk++;
        if ({result_hi, result_lo} !== 8'd66) begin
            n_fail++;
            $display("FAIL mul2: hi=%0d lo=%0d expected 4 2",
                     result_hi, result_lo);
        end
        accept_result();
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(4'd14, 4'd9, 4'd0, lat);
        n_chk++;
        if ({result_lo, result_hi, div_by_zero} !==
            {4'd0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL div0: q=%0d r=%0d dz=%b expected 0 0 1",
                     result_lo, result_hi, div_by_zero);
        end
        n_chk++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL div0_latency: got %0d expected 1", lat);
        end
        accept_result();
        do_op(4'd4, 4'd5, 4'd3, lat);
        n_chk++;
        if ({result_lo, result_hi, div_by_zero} !==
            {4'd6, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL xor_after_div0: lo=%0d hi=%0d dz=%b expected 6 0 0",
                     result_lo, result_hi, div_by_zero);
        end
        accept_result();
    endtask

    task automatic test_hold();
        int lat;
        do_op(4'd2, 4'd5, 4'd10, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            opcode   = 4'd9;
            op_a     = 4'(i);
            op_b     = 4'(15 - i);
            @(posedge clock); #1;
            n_chk++;
            if ({out_valid, in_ready, result_lo, result_hi, carry} !==
                {1'b1, 1'b0, 4'd15, 4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b lo=%0d hi=%0d c=%b expected 1 0 15 0 0",
                         i, out_valid, in_ready, result_lo, result_hi,
                         carry);
            end
        end
        in_valid = 1'b0;
        accept_result();
        @(posedge clock); #1;
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_no_queue: rdy=%b vld=%b expected 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_illegal();
        int lat;
        do_op(4'd9, 4'd15, 4'd1, lat);
        accept_result();
        do_op(4'd15, 4'd7, 4'd9, lat);
        n_chk++;
        if ({result_lo, result_hi, illegal_op, carry, div_by_zero} !==
            {4'd0, 4'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal: lo=%0d hi=%0d il=%b c=%b dz=%b expected 0 0 1 1 0",
                     result_lo, result_hi, illegal_op, carry,
                     div_by_zero);
        end
        accept_result();
        do_op(4'd5, 4'd9, 4'd3, lat);
        n_chk++;
        if ({result_lo, illegal_op, carry} !== {4'd5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL xnor_after_illegal: lo=%0d il=%b c=%b expected 5 0 1",
                     result_lo, illegal_op, carry);
        end
        accept_result();
    endtask

    task automatic test_reset_mid_iter();
        int lat;
        opcode   = 4'd13;
        op_a     = 4'd15;
        op_b     = 4'd15;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, out_valid, result_lo, result_hi, carry,
             div_by_zero, illegal_op} !== {1'b1, 1'b0, 4'd0, 4'd0,
             1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_iter: rdy=%b vld=%b lo=%0d hi=%0d c=%b dz=%b il=%b expected 1 0 0 0 0 0 0",
                     in_ready, out_valid, result_lo, result_hi, carry,
                     div_by_zero, illegal_op);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL after_release: rdy=%b vld=%b expected 1 0",
                     in_ready, out_valid);
        end
        do_op(4'd7, 4'd9, 4'd0, lat);
        n_chk++;
        if ({result_lo, result_hi, carry} !== {4'd2, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL shl: lo=%0d hi=%0d c=%b expected 2 0 0",
                     result_lo, result_hi, carry);
        end
        accept_result();
        do_op(4'd8, 4'd9, 4'd0, lat);
        n_chk++;
        if ({result_lo, result_hi, carry} !== {4'd4, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL shr: lo=%0d hi=%0d c=%b expected 4 0 0",
                     result_lo, result_hi, carry);
        end
        accept_result();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 4'd0;
        op_a      = 4'd0;
        op_b      = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        test_add_chain();
        test_sub_chain();
        test_mul_div();
        test_div_zero();
        test_hold();
        test_illegal();
        test_reset_mid_iter();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
